avalon_accum_agent: RTL

//  Avalon-MM responder (agent) that the Nios II host addresses as one peripheral. It

---
 rtl/accum_agent_pkg.sv | 18 +
 rtl/key_debouncer.sv | 67 ++++++
 rtl/avalon_accum_agent.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/accum_agent_pkg.sv
// Shared constants for the accumulate agent register block.
//   - Register word addresses on the Avalon-MM agent port.
//   - Bit positions inside the CTRL register.
//   - Width of the accepted-press event counter.
package accum_agent_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_SW   = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;
  localparam logic [1:0] ADDR_EVT  = 2'd3;

  localparam int CTRL_OVF    = 0;  // sticky overflow, write 1 to clear
  localparam int CTRL_IRQ_EN = 1;  // interrupt enable, R/W
  localparam int CTRL_KEY    = 2;  // debounced key level, RO

  localparam int EVT_W = 16;

endpackage

// File: rtl/key_debouncer.sv
// Synchronizes and debounces an active-low push button.
//   clk, reset_n  : clock and synchronous active-low reset
//   key_raw_n     : raw asynchronous key, low = pressed
//   key_level     : debounced key level (1 = released), resets to 1
//   press_pulse   : one-cycle pulse on each accepted 1->0 transition
// The counter only runs while the synchronized key disagrees with the
// accepted level; any agreement restarts it from zero, so a bounce shorter
// than DEBOUNCE_CYCLES never reaches the level register.
module key_debouncer
  import accum_agent_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_raw_n,
  output logic key_level,
  output logic press_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = key_raw_n;
    sync2_d = sync1_q;
    level_d = level_q;
    pulse_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        // Falling debounced level is a press; the pulse is registered so
        // it lines up with the level update.
        pulse_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b1;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_level   = level_q;
  assign press_pulse = pulse_q;

endmodule

// File: rtl/avalon_accum_agent.sv
// Avalon-MM agent with an 8-bit (DATA_W) key-driven accumulator.
//   clk, reset_n        : clock and synchronous active-low reset
//   avs_*               : Avalon-MM agent port, no waitrequest, read latency 1
//   irq                 : level interrupt = irq_en & ovf, registered
//   sw_in               : raw switches, synchronized before use
//   accum_key_n         : raw accumulate key, low = pressed
//   led_out             : registered copy of the accumulator
// Register map: 0 DATA (R/W), 1 SW (RO), 2 CTRL {key, irq_en, ovf}, 3 EVTCNT.
//
// Read handshake: a read strobe sampled at edge N (with no write in the same
// cycle) produces exactly one cycle of avs_readdatavalid=1 with avs_readdata
// during cycle N+1. readdata is forced to zero whenever readdatavalid is low.
module avalon_accum_agent
  import accum_agent_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DATA_W          = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic              irq,
  input  logic [DATA_W-1:0] sw_in,
  input  logic              accum_key_n,
  output logic [DATA_W-1:0] led_out
);

  logic [DATA_W-1:0] sw_s1_q,    sw_s1_d;
  logic [DATA_W-1:0] sw_s2_q,    sw_s2_d;
  logic [DATA_W-1:0] accum_q,    accum_d;
  logic              ovf_q,      ovf_d;
  logic              irq_en_q,   irq_en_d;
  logic [EVT_W-1:0]  evt_cnt_q,  evt_cnt_d;
  logic [31:0]       rdata_q,    rdata_d;
  logic              rvalid_q,   rvalid_d;
  logic              irq_q,      irq_d;
  logic [DATA_W-1:0] led_q,      led_d;

  logic              key_level;
  logic              press_pulse;
  logic [DATA_W:0]   sum;
  logic              wr_data, wr_ctrl, wr_evt, rd_en;
  logic [31:0]       rd_mux;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debouncer (
    .clk         (clk),
    .reset_n     (reset_n),
    .key_raw_n   (accum_key_n),
    .key_level   (key_level),
    .press_pulse (press_pulse)
  );

  always_comb begin
    sw_s1_d   = sw_in;
    sw_s2_d   = sw_s1_q;
    accum_d   = accum_q;
    ovf_d     = ovf_q;
    irq_en_d  = irq_en_q;
    evt_cnt_d = evt_cnt_q;
    rd_mux    = '0;

    sum     = {1'b0, accum_q} + {1'b0, sw_s2_q};
    wr_data = avs_write && avs_byteenable[0] && (avs_address == ADDR_DATA);
    wr_ctrl = avs_write && avs_byteenable[0] && (avs_address == ADDR_CTRL);
    wr_evt  = avs_write && (avs_address == ADDR_EVT);
    // A write in the same cycle suppresses the read response.
    rd_en   = avs_read && !avs_write;

    // Accumulate; a simultaneous DATA write takes precedence and the
    // addition (and its carry) is dropped.
    if (wr_data) begin
      accum_d = avs_writedata[DATA_W-1:0];
    end else if (press_pulse) begin
      accum_d = sum[DATA_W-1:0];
    end

    // Clear first, then set, so a carry in the same cycle keeps ovf high.
    if (wr_ctrl && avs_writedata[CTRL_OVF]) ovf_d = 1'b0;
    if (press_pulse && !wr_data && sum[DATA_W]) ovf_d = 1'b1;

    if (wr_ctrl) irq_en_d = avs_writedata[CTRL_IRQ_EN];

    // Increment first, then clear, so a clearing write wins.
    if (press_pulse) evt_cnt_d = evt_cnt_q + 1'b1;
    if (wr_evt)      evt_cnt_d = '0;

    case (avs_address)
      ADDR_DATA: rd_mux[DATA_W-1:0] = accum_q;
      ADDR_SW:   rd_mux[DATA_W-1:0] = sw_s2_q;
      ADDR_CTRL: begin
        rd_mux[CTRL_OVF]    = ovf_q;
        rd_mux[CTRL_IRQ_EN] = irq_en_q;
        rd_mux[CTRL_KEY]    = key_level;
      end
      default:   rd_mux[EVT_W-1:0] = evt_cnt_q;
    endcase

    rdata_d  = rd_en ? rd_mux : 32'd0;
    rvalid_d = rd_en;
    irq_d    = irq_en_q & ovf_q;
    led_d    = accum_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      accum_q   <= '0;
      ovf_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      evt_cnt_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      irq_q     <= 1'b0;
      led_q     <= '0;
    end else begin
      sw_s1_q   <= sw_s1_d;
      sw_s2_q   <= sw_s2_d;
      accum_q   <= accum_d;
      ovf_q     <= ovf_d;
      irq_en_q  <= irq_en_d;
      evt_cnt_q <= evt_cnt_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      irq_q     <= irq_d;
      led_q     <= led_d;
    end
  end

  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;
  assign irq               = irq_q;
  assign led_out           = led_q;

endmodule
